next_pc_unit: RTL and testbench

Next-address generator and hardware return-address stack for the instruction fetch path. It drives the program counter's `in` port and takes the program counter's registered `out` back as its `pc` input. Each cycle it selects the following instruction address: sequential, branch, call or return. It also holds up to `DEPTH` return addresses for nested subroutine calls.

---
 rtl/next_pc_if.sv | 33 +++
 rtl/next_pc_unit.sv | 99 +++++++++
 tb/tb_next_pc_unit.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/next_pc_if.sv
// next_pc_if: request/response bundle between the fetch control and
// next_pc_unit.
//   master : drives pc and the stall/ret/call/branch requests with their targets;
//            receives next_pc, stack_depth, overflow and underflow.
//   slave  : the next_pc_unit side of the same signals.
interface next_pc_if #(
  parameter int ADDR_W = 11,
  parameter int DEPTH  = 8
);
  localparam int DW = $clog2(DEPTH + 1);

  logic [ADDR_W-1:0] pc;
  logic              stall;
  logic              branch_en;
  logic [ADDR_W-1:0] branch_target;
  logic              call_en;
  logic [ADDR_W-1:0] call_target;
  logic              ret_en;
  logic [ADDR_W-1:0] next_pc;
  logic [DW-1:0]     stack_depth;
  logic              overflow;
  logic              underflow;

  modport master (
    output pc, stall, branch_en, branch_target, call_en, call_target, ret_en,
    input  next_pc, stack_depth, overflow, underflow
  );

  modport slave (
    input  pc, stall, branch_en, branch_target, call_en, call_target, ret_en,
    output next_pc, stack_depth, overflow, underflow
  );
endinterface

// File: rtl/next_pc_unit.sv
// next_pc_unit: picks the next fetch address and keeps a return-address
// stack for nested calls.
//   clock : rising-edge clock
//   reset : synchronous, active-high
//   bus   : next_pc_if slave (pc, stall, branch/call/return requests and
//           targets in; combinational next_pc, registered stack_depth and
//           sticky overflow/underflow out)
// Build option: define NEXT_PC_STACK_WRAP_EN for a circular stack. In that
// build a push onto a full stack overwrites the oldest entry. Without it, the
// stack saturates and the push is dropped.
module next_pc_unit #(
  parameter int ADDR_W = 11,
  parameter int DEPTH  = 8
) (
  input  logic      clock,
  input  logic      reset,
  next_pc_if.slave  bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int DW = $clog2(DEPTH + 1);

  logic [ADDR_W-1:0] mem_q [DEPTH];
  logic [PW-1:0]     sp_q, sp_d;     // next free slot
  logic [DW-1:0]     depth_q, depth_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;

  logic [ADDR_W-1:0] seq;
  logic [ADDR_W-1:0] top;
  logic              full;
  logic              empty;
  logic              push_wr;

  assign seq   = bus.pc + ADDR_W'(1);
  assign top   = mem_q[sp_q - PW'(1)];
  assign full  = (depth_q == DW'(DEPTH));
  assign empty = (depth_q == '0);

  always_comb begin
    bus.next_pc = seq;
    sp_d        = sp_q;
    depth_d     = depth_q;
    ovf_d       = ovf_q;
    unf_d       = unf_q;
    push_wr     = 1'b0;
    if (reset) begin
      bus.next_pc = '0;
      sp_d        = '0;
      depth_d     = '0;
      ovf_d       = 1'b0;
      unf_d       = 1'b0;
    end else if (bus.stall) begin
      bus.next_pc = bus.pc;
    end else if (bus.ret_en) begin
      if (!empty) begin
        bus.next_pc = top;
        sp_d        = sp_q - PW'(1);
        depth_d     = depth_q - DW'(1);
      end else begin
        unf_d = 1'b1;
      end
    end else if (bus.call_en) begin
      bus.next_pc = bus.call_target;
      if (!full) begin
        push_wr = 1'b1;
        sp_d    = sp_q + PW'(1);
        depth_d = depth_q + DW'(1);
      end else begin
        ovf_d = 1'b1;
`ifdef NEXT_PC_STACK_WRAP_EN
        // When the stack is full, sp_q points at the oldest entry, so writing
        // there and advancing the pointer drops the oldest address.
        push_wr = 1'b1;
        sp_d    = sp_q + PW'(1);
`else
        push_wr = 1'b0;
`endif
      end
    end else if (bus.branch_en) begin
      bus.next_pc = bus.branch_target;
    end
  end

  always_ff @(posedge clock) begin
    sp_q    <= sp_d;
    depth_q <= depth_d;
    ovf_q   <= ovf_d;
    unf_q   <= unf_d;
  end

  // Entry storage is not reset. The contents of invalid slots do not matter.
  always_ff @(posedge clock) begin
    if (push_wr) mem_q[sp_q] <= seq;
  end

  assign bus.stack_depth = depth_q;
  assign bus.overflow    = ovf_q;
  assign bus.underflow   = unf_q;
endmodule

// File: tb/tb_next_pc_unit.sv
module tb_next_pc_unit;
  localparam int ADDR_W = 11;
  localparam int DEPTH  = 8;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  next_pc_if #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) bus ();
  next_pc_unit #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    string       tag;
    logic [15:0] exp;
  } sb_t;

  sb_t sb_q[$];
  int  n_chk  = 0;
  int  n_pass = 0;

  task automatic chk(input string tag, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
  endtask

  // Drives one request cycle and queues the expected next_pc. The value is
  // checked mid-cycle, and the routine returns 1 ns after the following edge.
  task automatic cyc(input logic rst, input logic [10:0] pc_v, input logic st,
                     input logic re, input logic ca, input logic br,
                     input logic [10:0] bt, input logic [10:0] ct,
                     input logic [10:0] exp_npc, input string tag);
    sb_t e;
    @(negedge clock);
    reset             = rst;
    bus.pc            = pc_v;
    bus.stall         = st;
    bus.ret_en        = re;
    bus.call_en       = ca;
    bus.branch_en     = br;
    bus.branch_target = bt;
    bus.call_target   = ct;
    sb_q.push_back('{tag, {5'b0, exp_npc}});
    #1;
    e = sb_q.pop_front();
    chk(e.tag, {5'b0, bus.next_pc}, e.exp);
    @(posedge clock);
    #1;
  endtask

  task automatic state(input int d, input logic of, input logic uf, input string tag);
    chk({tag, "_depth"}, 16'(bus.stack_depth), 16'(d));
    chk({tag, "_ovf"},   {15'b0, bus.overflow},  {15'b0, of});
    chk({tag, "_unf"},   {15'b0, bus.underflow}, {15'b0, uf});
  endtask

  task automatic idle(input logic [10:0] pc_v, input string tag);
    cyc(1'b0, pc_v, 1'b0, 1'b0, 1'b0, 1'b0, 11'h0, 11'h0, pc_v + 11'd1, tag);
  endtask

  task automatic do_reset(input logic re);
    cyc(1'b1, 11'h123, 1'b0, re, 1'b0, 1'b0, 11'h0, 11'h0, 11'h000, "rst_npc");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.pc = '0; bus.stall = 0; bus.ret_en = 0; bus.call_en = 0;
    bus.branch_en = 0; bus.branch_target = '0; bus.call_target = '0;

    do_reset(1'b0);
    state(0, 0, 0, "reset");

    // Sequential addresses, including wrap at the top of memory.
    idle(11'h005, "seq5");
    idle(11'h7FF, "wrap");
    state(0, 0, 0, "seq");

    // Call, followed by the matching return.
    cyc(0, 11'h010, 0, 0, 1, 0, 11'h0, 11'h200, 11'h200, "call");
    state(1, 0, 0, "call");
    cyc(0, 11'h2A0, 0, 1, 0, 0, 11'h0, 11'h0, 11'h011, "ret");
    state(0, 0, 0, "ret");

    // Priority: stall beats all other requests, and ret beats call and branch.
    cyc(0, 11'h032, 0, 0, 1, 0, 11'h0, 11'h100, 11'h100, "call33");
    cyc(0, 11'h100, 1, 1, 1, 1, 11'h300, 11'h400, 11'h100, "stall");
    state(1, 0, 0, "stall");
    cyc(0, 11'h100, 0, 1, 1, 1, 11'h300, 11'h400, 11'h033, "prio");
    state(0, 0, 0, "prio");
    cyc(0, 11'h050, 0, 0, 0, 1, 11'h123, 11'h0, 11'h123, "branch");
    state(0, 0, 0, "branch");

    // Underflow sets a sticky flag.
    cyc(0, 11'h040, 0, 1, 0, 0, 11'h0, 11'h0, 11'h041, "unf_ret");
    state(0, 0, 1, "unf");
    for (int i = 0; i < 10; i++) idle(11'h041 + 11'(i), "unf_idle");
    state(0, 0, 1, "unf_sticky");

    // Overflow: nine calls into an eight-entry stack, then nine returns.
    do_reset(1'b0);
    state(0, 0, 0, "rst2");
    for (int i = 0; i < 9; i++) begin
      cyc(0, 11'(i), 0, 0, 1, 0, 11'h0, 11'h300 + 11'(i), 11'h300 + 11'(i), "ovf_call");
      if (i == 7) state(8, 0, 0, "full");
    end
    state(8, 1, 0, "ovf");
    for (int i = 0; i < 8; i++) begin
`ifdef NEXT_PC_STACK_WRAP_EN
      cyc(0, 11'h700, 0, 1, 0, 0, 11'h0, 11'h0, 11'h009 - 11'(i), "ovf_ret");
`else
      cyc(0, 11'h700, 0, 1, 0, 0, 11'h0, 11'h0, 11'h008 - 11'(i), "ovf_ret");
`endif
    end
    state(0, 1, 0, "drained");
    cyc(0, 11'h700, 0, 1, 0, 0, 11'h0, 11'h0, 11'h701, "ovf_ret9");
    state(0, 1, 1, "ovf_unf");

    // Reset in the middle of operation.
    do_reset(1'b0);
    for (int i = 0; i < 3; i++)
      cyc(0, 11'h020 + 11'(i), 0, 0, 1, 0, 11'h0, 11'h400, 11'h400, "mid_call");
    state(3, 0, 0, "mid");
    do_reset(1'b1);
    state(0, 0, 0, "mid_rst");
    cyc(0, 11'h060, 0, 1, 0, 0, 11'h0, 11'h0, 11'h061, "post_rst_ret");
    state(0, 0, 1, "post_rst");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
